// File: rtl/ysyx_22050133_iter_div.sv
// Iterative radix-2 restoring divider serving the EXU divide handshake.
// Handles DIV/DIVU/REM/REMU and their 32-bit W forms with a fixed latency
// of 64 (or 32 for W forms) cycles from accept to the out_valid strobe.
module ysyx_22050133_iter_div #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned HW = 32;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic            w_r;
  logic            s_r;
  logic            neg_a_r;
  logic            neg_b_r;
  logic            dbz_r;
  logic [XLEN-1:0] abs_b_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_last;

  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] quo_init;

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] q_sgn;
  logic [XLEN-1:0] r_sgn;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  assign div_ready = (state == IDLE);

  // Operand preparation: extend W operands, then split into sign and magnitude
  always_comb begin
    if (divw) begin
      a_ext = div_signed ? {{(XLEN-HW){dividend[HW-1]}}, dividend[HW-1:0]}
                         : {{(XLEN-HW){1'b0}}, dividend[HW-1:0]};
      b_ext = div_signed ? {{(XLEN-HW){divisor[HW-1]}}, divisor[HW-1:0]}
                         : {{(XLEN-HW){1'b0}}, divisor[HW-1:0]};
    end else begin
      a_ext = dividend;
      b_ext = divisor;
    end
    a_neg = div_signed & a_ext[XLEN-1];
    b_neg = div_signed & b_ext[XLEN-1];
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;
    // W magnitudes are parked in the top half so 32 shifts consume them fully
    quo_init = divw ? {abs_a[HW-1:0], {(XLEN-HW){1'b0}}} : abs_a;
  end

  // One restoring shift-subtract step on the XLEN+1-bit partial remainder
  always_comb begin
    shifted  = {rem_r, quo_r[XLEN-1]};
    fits     = (shifted >= {1'b0, abs_b_r});
    rem_next = fits ? XLEN'(shifted - {1'b0, abs_b_r}) : shifted[XLEN-1:0];
    quo_next = {quo_r[XLEN-2:0], fits};
  end

  // Final sign fix-up; a zero divisor already leaves |dividend| as the
  // remainder, so only the quotient needs the all-ones override
  always_comb begin
    q_mag = w_r ? {{(XLEN-HW){1'b0}}, quo_next[HW-1:0]} : quo_next;
    r_mag = rem_next;
    q_sgn = (s_r & (neg_a_r ^ neg_b_r)) ? -q_mag : q_mag;
    if (dbz_r) begin
      q_sgn = '1;
    end
    r_sgn = (s_r & neg_a_r) ? -r_mag : r_mag;
    q_fin = w_r ? {{(XLEN-HW){q_sgn[HW-1]}}, q_sgn[HW-1:0]} : q_sgn;
    r_fin = w_r ? {{(XLEN-HW){r_sgn[HW-1]}}, r_sgn[HW-1:0]} : r_sgn;
  end

  // Control FSM with the iteration datapath and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      n_last    <= '0;
      w_r       <= 1'b0;
      s_r       <= 1'b0;
      neg_a_r   <= 1'b0;
      neg_b_r   <= 1'b0;
      dbz_r     <= 1'b0;
      abs_b_r   <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (div_valid && !flush) begin
            w_r     <= divw;
            s_r     <= div_signed;
            neg_a_r <= a_neg;
            neg_b_r <= b_neg;
            dbz_r   <= (b_ext == '0);
            abs_b_r <= abs_b;
            quo_r   <= quo_init;
            rem_r   <= '0;
            cnt     <= '0;
            n_last  <= divw ? CW'(HW - 1) : CW'(XLEN - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem_r <= rem_next;
            quo_r <= quo_next;
            cnt   <= cnt + CW'(1);
            if (cnt == n_last) begin
              quotient  <= q_fin;
              remainder <= r_fin;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_iter_div.sv
// Self-checking bench for ysyx_22050133_iter_div: an arithmetic reference
// model with a timing countdown, a per-cycle compare process, and literal
// expectations for a set of directed divide requests.
module tb_ysyx_22050133_iter_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic        m_busy;
  logic        m_valid;
  int          m_cnt;
  int          m_cycles;
  logic [63:0] m_q;
  logic [63:0] m_r;
  logic [127:0] p_res;

  // literal expectations armed by the stimulus
  int          lit_seq = 0;
  int          lit_done = 0;
  logic [63:0] lit_q = '0;
  logic [63:0] lit_r = '0;
  int          lit_lat = 0;
  logic        seen_reset = 1'b0;
  logic        done_req = 1'b0;

  always #5 clk = ~clk;

  ysyx_22050133_iter_div #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // RV64M divide semantics in plain arithmetic, returns {quotient, remainder}
  function automatic logic [127:0] model(input logic w, input logic s,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] q32;
    logic [31:0] r32;
    logic [63:0] q;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == '0) begin
        q32 = '1;
        r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = '0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == '0) begin
        q = '1;
        r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = '0;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    return {q, r};
  endfunction

  // Model: accept when free, count down N edges, publish result for one cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_cnt    <= 0;
      m_cycles <= 0;
      m_q      <= '0;
      m_r      <= '0;
      p_res    <= '0;
    end else begin
      m_valid  <= 1'b0;
      m_cycles <= m_cycles + 1;
      if (m_busy) begin
        if (flush) begin
          m_busy <= 1'b0;
        end else if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_q     <= p_res[127:64];
          m_r     <= p_res[63:0];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (!m_valid && div_valid && !flush) begin
        p_res    <= model(divw, div_signed, dividend, divisor);
        m_busy   <= 1'b1;
        m_cnt    <= divw ? 32 : 64;
        m_cycles <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: reset values right after rst falls, model match every cycle
  always begin
    @(negedge clk or negedge rst);
    if (!rst) begin
      #1;
      seen_reset = 1'b1;
      chk("rst_ready", {63'd0, div_ready}, 64'd1);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_quotient", quotient, 64'd0);
      chk("rst_remainder", remainder, 64'd0);
    end else if (seen_reset) begin
      chk("div_ready", {63'd0, div_ready}, {63'd0, !m_busy && !m_valid});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      if (out_valid && lit_seq != lit_done) begin
        chk("lit_quotient", quotient, lit_q);
        chk("lit_remainder", remainder, lit_r);
        chk("lit_latency", 64'(m_cycles), 64'(lit_lat));
        lit_done = lit_seq;
      end
      if (done_req) begin
        chk("all_results_seen", 64'(lit_done), 64'(lit_seq));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge, then hold garbage that must be ignored
  task automatic issue(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input bit arm, input logic [63:0] eq, input logic [63:0] er, input int lat);
    divw       = w;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    if (arm) begin
      lit_q   = eq;
      lit_r   = er;
      lit_lat = lat;
      lit_seq = lit_seq + 1;
    end
    idle(1);
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    divw       = ~w;
    div_signed = ~s;
    idle(3);
    div_valid  = 1'b0;
  endtask

  task automatic run(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] eq, input logic [63:0] er, input int lat);
    issue(w, s, a, b, 1'b1, eq, er, lat);
    idle(lat + 2);
  endtask

  initial begin
    #3 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    idle(2);

    run(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    run(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 64'd0, 64);
    run(1'b0, 1'b1, 64'h8000_0000_0000_0005, 64'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0005, 64);
    run(1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 64'd0, 32);
    run(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h10,
        64'h0000_0000_0FFF_FFFF, 64'hF, 32);
    run(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
        64'h5555_5555_5555_5555, 64'd0, 64);
    run(1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    run(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1,
        64'hFFFF_FFFF_8000_0000, 64'd0, 32);
    run(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_9ABC_DEF0, 32);
    run(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000,
        64'h0000_0000_1234_5678, 64'h0000_0000_9ABC_DEF0, 64);
    run(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
        64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 64);

    // flush on the 10th busy cycle; results of the previous op must hold
    issue(1'b0, 1'b0, 64'd1000, 64'd3, 1'b0, '0, '0, 0);
    idle(5);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(70);
    // flush together with a request: nothing may be accepted
    div_valid = 1'b1;
    flush     = 1'b1;
    dividend  = 64'd9;
    divisor   = 64'd3;
    idle(1);
    div_valid = 1'b0;
    flush     = 1'b0;
    idle(3);
    run(1'b0, 1'b0, 64'd50, 64'd5, 64'd10, 64'd0, 64);

    // asynchronous reset in the middle of an operation
    issue(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, '0, '0, 0);
    idle(15);
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    idle(1);
    run(1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 64);

    done_req = 1'b1;
    idle(5);
    $display("FAIL watchdog: compare process did not finish at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22050133_iter_div.md
Name: ysyx_22050133_iter_div

Overview:
- Iterative radix-2 integer divider: the responder side of the EXU's div_valid/div_ready divide handshake.
- Accepts one RV64M divide request at a time: DIV, DIVU, REM, REMU, and the W variants.
- Computes the quotient and remainder over a fixed number of cycles.
- Presents the result with a one-cycle out_valid strobe, and holds it until the next accepted request.

Parameters:
- XLEN, 64, operand and result width; the W variants always use the low 32 bits.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; named as in the rest of the codebase.
- flush  in  1  synchronous abort of any in-flight divide.
- div_valid  in  1  request valid.
- divw  in  1  1 = 32-bit operation (DIVW/DIVUW/REMW/REMUW).
- div_signed  in  1  1 = signed operands, 0 = unsigned.
- dividend  in  XLEN  dividend.
- divisor  in  XLEN  divisor.
- div_ready  out  1  high only in IDLE: the block can accept a request.
- out_valid  out  1  one-cycle strobe: quotient and remainder are valid.
- quotient  out  XLEN  registered quotient.
- remainder  out  XLEN  registered remainder.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; div_ready=1; out_valid=0.
  - quotient=0; remainder=0; iteration counter=0.
  - Takes effect immediately, including in the middle of an operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when div_valid=1 and flush=0 at a rising edge.
  - On accept, latch: divw, div_signed, sign of each operand, absolute values, divide-by-zero flag (divisor==0), and N = divw ? 32 : 64.
  - Then go to BUSY.
- Operand preparation when divw=1:
  - Use bits [31:0] only.
  - Signed: sign-extend them. Unsigned: zero-extend them.
- BUSY:
  - One restoring shift-subtract step per cycle.
  - Partial remainder is XLEN+1 bits wide; unsigned magnitudes throughout.
  - After exactly N iterations, go to DONE.
- Result registration (on the edge that enters DONE):
  - quotient is negated when signed and the operand signs differ.
  - remainder takes the dividend's sign when signed.
- Latency: the request is accepted at edge k; out_valid is high from edge k+N to edge k+N+1. This holds for every operand value, including special cases.
- DONE:
  - out_valid=1 for exactly one cycle, then return to IDLE.
  - div_ready=0 in DONE, so back-to-back requests are spaced by at least N+1 cycles.
- div_valid outside IDLE is ignored; requests are not queued.
- Operands may change after acceptance without affecting the result.
- Divide by zero:
  - quotient = all ones (divw: 64'hFFFF_FFFF_FFFF_FFFF).
  - remainder = the original dividend (divw: sext(dividend[31:0])).
  - Both independent of signedness.
- Signed overflow (most-negative / -1):
  - quotient = most-negative value; remainder = 0.
  - For divw this is quotient = 64'hFFFF_FFFF_8000_0000.
  - No trap.
- divw results: the 32-bit quotient and remainder are sign-extended to XLEN, for both signed and unsigned variants.
- quotient and remainder:
  - Change only on the edge entering DONE, on reset, or never.
  - A flush leaves them unchanged.
  - They hold their values until the next DONE.
- flush=1 at an edge:
  - Return to IDLE from any state; out_valid=0 on the next cycle.
  - If flush and div_valid are high together, flush wins and the request is not accepted.
  - If flush arrives during DONE, the strobe still occurs in that cycle; state goes to IDLE.
- No combinational path from inputs to outputs; div_ready is decoded from state only.

Test Plan:
- DIVU 64-bit, dividend=100, divisor=7 -> quotient=14, remainder=2; out_valid is high exactly 64 cycles after the accept edge, for one cycle only; div_ready=0 throughout BUSY and DONE.
- DIV signed, dividend=-7 (0xFFFF_FFFF_FFFF_FFF9), divisor=2 -> quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=0xFFFF_FFFF_FFFF_FFFF. Overflow case: 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
- Divide by zero, signed, dividend=0x8000_0000_0000_0005, divisor=0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x8000_0000_0000_0005; latency still 64 cycles.
- DIVW, dividend=0x0000_0001_8000_0000, divisor=0x0000_0000_FFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000, remainder=0, latency 32 cycles. DIVUW, 0xFFFF_FFFF / 0x10 -> quotient=0x0000_0000_0FFF_FFFF, remainder=0xF.
- Flush on the 10th BUSY cycle -> div_ready=1 on the next cycle, no out_valid, previous results held; a new request (50/5) is then accepted and gives quotient=10, remainder=0 after 64 cycles.
- Drive rst low asynchronously mid-operation (between clock edges) -> out_valid=0, quotient=remainder=0, div_ready=1 immediately; after release, a fresh request completes normally.
